// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, S-box, Rcon and round-transform helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int unsigned nr_of(input int unsigned key_bits);
    int unsigned nk;
    nk = key_bits / 32;
    return nk + 6;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = 11'd2047 - {b, 3'b000};
    return SBOX[base -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One on-the-fly key expansion step; the low 128 bits of the result are the round key.
module aes_key_step #(
  parameter int unsigned KEY_BITS = 128,
  parameter int unsigned STEP_W   = 4
) (
  input  logic [KEY_BITS-1:0] window,
  input  logic [STEP_W-1:0]   step,
  output logic [KEY_BITS-1:0] next_window_c
);
  import aes_pkg::*;

  if (KEY_BITS == 128) begin : g_k128
    logic [31:0]  temp_c;
    logic [127:0] nw_c;

    // Window holds round key step-1; produce round key step.
    always_comb begin
      temp_c = sub_word(rot_word(window[31:0])) ^ {rcon(4'(step - STEP_W'(1))), 24'h0};
      nw_c[127:96] = window[127:96] ^ temp_c;
      nw_c[95:64]  = window[95:64]  ^ nw_c[127:96];
      nw_c[63:32]  = window[63:32]  ^ nw_c[95:64];
      nw_c[31:0]   = window[31:0]   ^ nw_c[63:32];
    end

    assign next_window_c = nw_c;
  end else begin : g_k256
    logic [31:0]  temp_c;
    logic [127:0] new_c;
    logic [255:0] nw_c;

    // Window holds round keys step-2 and step-1; step 1 reuses the key's low half.
    // Even steps apply RotWord+Rcon, odd steps SubWord only.
    always_comb begin
      if (step[0])
        temp_c = sub_word(window[31:0]);
      else
        temp_c = sub_word(rot_word(window[31:0])) ^
                 {rcon(4'((step >> 1) - STEP_W'(1))), 24'h0};
      new_c[127:96] = window[255:224] ^ temp_c;
      new_c[95:64]  = window[223:192] ^ new_c[127:96];
      new_c[63:32]  = window[191:160] ^ new_c[95:64];
      new_c[31:0]   = window[159:128] ^ new_c[63:32];
      if (step == STEP_W'(1))
        nw_c = window;
      else
        nw_c = {window[127:0], new_c};
    end

    assign next_window_c = nw_c;
  end

endmodule

// File: rtl/aes_core_param.sv
// Iterative AES encryption core, one round per clock, AES-128 or AES-256.
// Optional abort input enabled by defining AES_ABORT_EN.
module aes_core_param
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_BITS-1:0] key,
  input  logic [127:0]        plaintext,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        cyphertext,
  output logic                busy
`ifdef AES_ABORT_EN
  ,
  input  logic                abort
`endif
);

  localparam int unsigned NR    = nr_of(KEY_BITS);
  localparam int unsigned RND_W = $clog2(NR + 1);

  aes_state_e          fsm;
  logic [127:0]        blk;
  logic [KEY_BITS-1:0] win;
  logic [RND_W-1:0]    rnd;

  logic [KEY_BITS-1:0] win_next_c;
  logic [127:0]        sb_c;
  logic [127:0]        round_out_c;
  logic                last_c;

  aes_key_step #(
    .KEY_BITS (KEY_BITS),
    .STEP_W   (RND_W)
  ) u_key_step (
    .window        (win),
    .step          (rnd),
    .next_window_c (win_next_c)
  );

  // One full round; the final round skips MixColumns.
  always_comb begin
    last_c      = (rnd == RND_W'(NR));
    sb_c        = shift_rows(sub_bytes(blk));
    round_out_c = (last_c ? sb_c : mix_columns(sb_c)) ^ win_next_c[127:0];
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      cyphertext <= '0;
      blk        <= '0;
      win        <= '0;
      rnd        <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            blk      <= plaintext ^ key[KEY_BITS-1 -: 128];
            win      <= key;
            rnd      <= RND_W'(1);
            fsm      <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ROUND: begin
`ifdef AES_ABORT_EN
          if (abort) begin
            fsm      <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            rnd      <= '0;
          end else
`endif
          begin
            blk <= round_out_c;
            win <= win_next_c;
            if (last_c) begin
              fsm        <= DONE;
              out_valid  <= 1'b1;
              cyphertext <= round_out_c;
              rnd        <= '0;
            end else begin
              rnd <= rnd + RND_W'(1);
            end
          end
        end
        DONE: begin
`ifdef AES_ABORT_EN
          if (abort) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end else
`endif
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          rnd       <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_core_param.md
AES_CORE_PARAM -- requirements
Module: aes_core_param

Interface
REQ-001 SHALL have parameter KEY_BITS, default 128, meaning: cipher key length; legal values 128 and 256 only.
REQ-002 SHALL derive NK = KEY_BITS/32 and NR = NK+6, giving 10 rounds for AES-128 and 14 for AES-256.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): input handshake.
REQ-006 SHALL have ports key (input, KEY_BITS) and plaintext (input, 128): FIPS-197 byte order, MSB is byte 0.
REQ-007 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): output handshake.
REQ-008 SHALL have port cyphertext, output, 128 bits: encrypted block.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL implement a 3-state FSM: IDLE, ROUND, DONE.
REQ-011 SHALL drive in_ready = 1 only in IDLE.
REQ-012 SHALL accept a block on the edge where in_valid && in_ready; on that edge: state <= plaintext ^ key[KEY_BITS-1 -: 128], round counter <= 1, key window <= key, FSM -> ROUND.
REQ-013 SHALL perform one full round per clk in ROUND: SubBytes, ShiftRows, MixColumns, AddRoundKey; the round-NR step omits MixColumns.
REQ-014 SHALL expand round keys on the fly, one round key per cycle.
REQ-015 SHALL handle AES-256 key expansion: alternate SubWord+RotWord+Rcon steps with SubWord-only steps per FIPS-197 section 5.2.
REQ-016 SHALL index Rcon by key-expansion step, with wrap-free counters sized for NR.
REQ-017 SHALL move ROUND -> DONE on the edge completing round NR, giving out_valid exactly NR cycles after the accept edge.
REQ-018 SHALL, in DONE, hold out_valid = 1 and keep cyphertext stable until out_ready = 1.
REQ-019 SHALL, on the edge with out_valid && out_ready, go DONE -> IDLE and drop out_valid.
REQ-020 SHALL ignore in_valid, key and plaintext changes while not in IDLE.
REQ-021 SHALL ignore out_ready while not in DONE.
REQ-022 SHALL hold cyphertext at its last value after handoff, and at 0 before the first result.

Reset
REQ-023 SHALL, on rst_n = 0 at any time including mid-round: FSM -> IDLE, in_ready = 1 (after reset), out_valid = 0, busy = 0, cyphertext = 0, counters = 0, and discard any partial block.
REQ-024 SHALL accept a new block on the first clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with AES_ABORT_EN defined, add input abort (1 bit).
REQ-026 SHALL, with AES_ABORT_EN defined, treat abort = 1 on a clk edge in ROUND or DONE as: FSM -> IDLE, out_valid = 0, cyphertext unchanged; abort in IDLE has no effect.
REQ-027 SHALL, without AES_ABORT_EN, have no abort port and no abort logic.

Structure
REQ-028 SHALL place in package aes_pkg: FSM state enum, Rcon table (10 entries), sbox function/table, and an nr_of(KEY_BITS) constant function.
REQ-029 SHALL implement the per-cycle key-window update in sub-module aes_key_step (inputs: window, step index, KEY_BITS; output: next window).
REQ-030 SHALL use combinational S-boxes so one round completes per cycle.

Verification
REQ-031 SHALL cover this scenario: KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> cyphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
REQ-032 SHALL cover this scenario: KEY_BITS=256, key 000102...1e1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, out_valid exactly 14 cycles after accept.
REQ-033 SHALL cover this scenario: KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready held 0 for 5 cycles -> 3925841d02dc09fbdc118597196a0b32 stable, out_valid high throughout, in_ready = 0.
REQ-034 SHALL cover this scenario: rst_n pulsed low at round 5 -> out_valid = 0, in_ready = 1 after release; the next block encrypts correctly per REQ-031.
REQ-035 SHALL cover this scenario: back-to-back blocks with in_valid held high and out_ready = 1 -> each accepted one cycle after the previous handoff, correct results, no block dropped or duplicated.
REQ-036 SHALL cover this scenario: with AES_ABORT_EN defined, abort at round 3 -> IDLE next cycle, no out_valid pulse, cyphertext keeps its prior value.
